// File: rtl/ysyx_ifq_pkg.sv
// RV32 opcode constants and pre-decode flag layout shared by the IFQ and the IDU.
package ysyx_macro;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int PD_BRANCH = 0;
  localparam int PD_JAL    = 1;
  localparam int PD_JALR   = 2;
  localparam int PD_LOAD   = 3;
  localparam int PD_STORE  = 4;
  localparam int PD_SYS    = 5;
  localparam int PD_ILL    = 6;
  localparam int PD_W      = 7;

endpackage

// File: rtl/ysyx_ifq_predecode.sv
// Combinational RV32 pre-decoder: low opcode bits of an instruction -> one-hot class flags.
// Only inst[6:0] matters, so the port carries just those bits.
module ysyx_ifq_predecode
  import ysyx_macro::*;
(
  input  logic [6:0]      opcode,
  output logic [PD_W-1:0] pd
);

  always_comb begin
    pd            = '0;
    pd[PD_BRANCH] = (opcode == OP_BRANCH);
    pd[PD_JAL]    = (opcode == OP_JAL);
    pd[PD_JALR]   = (opcode == OP_JALR);
    pd[PD_LOAD]   = (opcode == OP_LOAD);
    pd[PD_STORE]  = (opcode == OP_STORE);
    pd[PD_SYS]    = (opcode == OP_SYSTEM);
    // Every class opcode ends in 2'b11, so ill is naturally exclusive with the rest.
    pd[PD_ILL]    = (opcode[1:0] != 2'b11);
  end

endmodule

// File: rtl/ysyx_ifq.sv
// Instruction fetch queue between IFU and IDU: circular FIFO of {pc, inst, pre-decode}
// entries with flush-on-redirect.
module ysyx_ifq
  import ysyx_macro::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prev_valid,
  output logic                  ready_o,
  input  logic [DATA_W-1:0]     inst_i,
  input  logic [ADDR_W-1:0]     pc_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  next_ready,
  output logic [DATA_W-1:0]     inst_o,
  output logic [ADDR_W-1:0]     pc_o,
  output logic [PD_W-1:0]       pd_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  ENT_W    = ADDR_W + DATA_W + PD_W;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [ENT_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2:0]   count;
  logic [PD_W-1:0]       pd_in;
  logic                  enq;
  logic                  deq;

  ysyx_ifq_predecode u_predecode (
    .opcode (inst_i[6:0]),
    .pd     (pd_in)
  );

  // Handshakes depend only on registered occupancy, never on the far side's ready.
  assign ready_o = (count != FULL_CNT);
  assign valid_o = (count != '0);
  assign enq     = prev_valid & ready_o & ~flush_i;
  assign deq     = valid_o & next_ready & ~flush_i;
  assign count_o = count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end

  // Storage is never cleared; the empty check below hides stale contents.
  always_ff @(posedge clk) begin
    if (rst && enq) mem[tail] <= {pc_i, inst_i, pd_in};
  end

  assign {pc_o, inst_o, pd_o} = valid_o ? mem[head] : '0;

endmodule

// File: tb/tb_ysyx_ifq.sv
// Bench for ysyx_ifq: hand-written vector table for the directed scenarios, then
// random traffic checked against a queue-based reference model.
module tb_ysyx_ifq;

  logic        clk = 1'b0;
  logic        rst, prev_valid, flush_i, next_ready;
  logic        ready_o, valid_o;
  logic [31:0] inst_i, pc_i, inst_o, pc_o;
  logic [6:0]  pd_o;
  logic [2:0]  count_o;

  int n_vec = 0;
  int n_bad = 0;

  ysyx_ifq dut (
    .clk        (clk),
    .rst        (rst),
    .prev_valid (prev_valid),
    .ready_o    (ready_o),
    .inst_i     (inst_i),
    .pc_i       (pc_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .next_ready (next_ready),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .pd_o       (pd_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, pv, fl, nr;
    logic [31:0] pc, inst;
    logic        ev, er;
    logic [2:0]  ec;
    logic [31:0] epc, einst;
    logic [6:0]  epd;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  vec_t vecs[$];
  ent_t model_q[$];

  function automatic void add(logic r, logic pv, logic fl, logic nr,
                              logic [31:0] pc, logic [31:0] inst,
                              logic ev, logic er, logic [2:0] ec,
                              logic [31:0] epc, logic [31:0] einst, logic [6:0] epd);
    vec_t v;
    v.r = r; v.pv = pv; v.fl = fl; v.nr = nr; v.pc = pc; v.inst = inst;
    v.ev = ev; v.er = er; v.ec = ec; v.epc = epc; v.einst = einst; v.epd = epd;
    vecs.push_back(v);
  endfunction

  // Class of an instruction straight from the opcode table.
  function automatic logic [6:0] ref_pd(logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    if (op[1:0] != 2'b11) return 7'h40;
    case (op)
      7'h63:   return 7'h01;
      7'h6F:   return 7'h02;
      7'h67:   return 7'h04;
      7'h03:   return 7'h08;
      7'h23:   return 7'h10;
      7'h73:   return 7'h20;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [31:0] ent_pc(int k);
    return 32'h300 + 32'(4 * k);
  endfunction

  function automatic logic [31:0] ent_inst(int k);
    return 32'h13 | (32'(k) << 20);
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(logic r, logic pv, logic fl, logic nr,
                                logic [31:0] pc, logic [31:0] inst);
    rst = r; prev_valid = pv; flush_i = fl; next_ready = nr; pc_i = pc; inst_i = inst;
    @(posedge clk);
    #1;
  endtask

  // Advance the reference queue by one edge with the inputs that were applied.
  task automatic model_step(logic r, logic pv, logic fl, logic nr,
                            logic [31:0] pc, logic [31:0] inst);
    bit do_enq, do_deq;
    ent_t e;
    if (!r || fl) begin
      model_q.delete();
    end else begin
      do_enq = pv && (model_q.size() < 4);
      do_deq = nr && (model_q.size() > 0);
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) begin
        e.pc = pc; e.inst = inst;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic check_model(int cyc);
    logic [31:0] epc, einst;
    logic [6:0]  epd;
    epc = 0; einst = 0; epd = 0;
    if (model_q.size() != 0) begin
      epc = model_q[0].pc; einst = model_q[0].inst; epd = ref_pd(model_q[0].inst);
    end
    check_output($sformatf("r%0d.valid", cyc), 32'(valid_o), 32'(model_q.size() != 0));
    check_output($sformatf("r%0d.ready", cyc), 32'(ready_o), 32'(model_q.size() != 4));
    check_output($sformatf("r%0d.count", cyc), 32'(count_o), 32'(model_q.size()));
    check_output($sformatf("r%0d.pc", cyc), pc_o, epc);
    check_output($sformatf("r%0d.inst", cyc), inst_o, einst);
    check_output($sformatf("r%0d.pd", cyc), 32'(pd_o), 32'(epd));
  endtask

  initial begin
    logic [31:0] rnd, rinst, rpc;
    logic        rr, rpv, rfl, rnr;
    logic [6:0]  ops [7];

    rst = 1'b0; prev_valid = 1'b0; flush_i = 1'b0; next_ready = 1'b0;
    pc_i = '0; inst_i = '0;

    // Reset then idle.
    add(0,0,0,0, 0,0,                      0,1,0, 0,0,0);
    add(0,0,0,0, 0,0,                      0,1,0, 0,0,0);
    add(1,0,0,0, 0,0,                      0,1,0, 0,0,0);
    // Fill with the IDU stalled, then one rejected push while full.
    add(1,1,0,0, 32'h80000000,32'h13,      1,1,1, 32'h80000000,32'h13,7'h00);
    add(1,1,0,0, 32'h80000004,32'h6F,      1,1,2, 32'h80000000,32'h13,7'h00);
    add(1,1,0,0, 32'h80000008,32'h8067,    1,1,3, 32'h80000000,32'h13,7'h00);
    add(1,1,0,0, 32'h8000000C,32'h2003,    1,0,4, 32'h80000000,32'h13,7'h00);
    add(1,1,0,0, 32'h80000010,32'h13,      1,0,4, 32'h80000000,32'h13,7'h00);
    // Drain in order; next_ready ignored once empty.
    add(1,0,0,1, 0,0,                      1,1,3, 32'h80000004,32'h6F,7'h02);
    add(1,0,0,1, 0,0,                      1,1,2, 32'h80000008,32'h8067,7'h04);
    add(1,0,0,1, 0,0,                      1,1,1, 32'h8000000C,32'h2003,7'h08);
    add(1,0,0,1, 0,0,                      0,1,0, 0,0,0);
    add(1,0,0,1, 0,0,                      0,1,0, 0,0,0);
    // Pre-decode sweep, with a full+dequeue cycle that must not enqueue 0x110.
    add(1,1,0,0, 32'h100,32'h63,           1,1,1, 32'h100,32'h63,7'h01);
    add(1,1,0,0, 32'h104,32'h2023,         1,1,2, 32'h100,32'h63,7'h01);
    add(1,1,0,0, 32'h108,32'h73,           1,1,3, 32'h100,32'h63,7'h01);
    add(1,1,0,0, 32'h10C,32'h0,            1,0,4, 32'h100,32'h63,7'h01);
    add(1,1,0,1, 32'h110,32'h13,           1,1,3, 32'h104,32'h2023,7'h10);
    add(1,0,0,1, 0,0,                      1,1,2, 32'h108,32'h73,7'h20);
    add(1,0,0,1, 0,0,                      1,1,1, 32'h10C,32'h0,7'h40);
    add(1,0,0,1, 0,0,                      0,1,0, 0,0,0);
    // Steady simultaneous push/pop at count 2; pointers wrap several times.
    add(1,1,0,0, ent_pc(0),ent_inst(0),    1,1,1, ent_pc(0),ent_inst(0),7'h00);
    add(1,1,0,0, ent_pc(1),ent_inst(1),    1,1,2, ent_pc(0),ent_inst(0),7'h00);
    for (int j = 0; j < 6; j++)
      add(1,1,0,1, ent_pc(j+2),ent_inst(j+2), 1,1,2, ent_pc(j+1),ent_inst(j+1),7'h00);
    add(1,0,0,1, 0,0,                      1,1,1, ent_pc(7),ent_inst(7),7'h00);
    add(1,0,0,1, 0,0,                      0,1,0, 0,0,0);
    // Flush beats a simultaneous push and pop; the flushed-cycle inst never shows up.
    add(1,1,0,0, 32'h400,32'h13,           1,1,1, 32'h400,32'h13,7'h00);
    add(1,1,0,0, 32'h404,32'h13,           1,1,2, 32'h400,32'h13,7'h00);
    add(1,1,0,0, 32'h408,32'h13,           1,1,3, 32'h400,32'h13,7'h00);
    add(1,1,1,1, 32'hDEAD0,32'h6F,         0,1,0, 0,0,0);
    add(1,0,0,1, 0,0,                      0,1,0, 0,0,0);
    add(1,1,0,0, 32'h500,32'h63,           1,1,1, 32'h500,32'h63,7'h01);
    add(1,1,0,0, 32'h504,32'h6F,           1,1,2, 32'h500,32'h63,7'h01);
    // Reset mid-operation wins over a pending push.
    add(0,1,1,1, 32'h600,32'h13,           0,1,0, 0,0,0);
    add(1,0,0,0, 0,0,                      0,1,0, 0,0,0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].r, vecs[i].pv, vecs[i].fl, vecs[i].nr, vecs[i].pc, vecs[i].inst);
      check_output($sformatf("v%0d.valid", i), 32'(valid_o), 32'(vecs[i].ev));
      check_output($sformatf("v%0d.ready", i), 32'(ready_o), 32'(vecs[i].er));
      check_output($sformatf("v%0d.count", i), 32'(count_o), 32'(vecs[i].ec));
      check_output($sformatf("v%0d.pc", i), pc_o, vecs[i].epc);
      check_output($sformatf("v%0d.inst", i), inst_o, vecs[i].einst);
      check_output($sformatf("v%0d.pd", i), 32'(pd_o), 32'(vecs[i].epd));
    end

    // Random traffic against the reference queue, starting from reset.
    ops[0] = 7'h63; ops[1] = 7'h6F; ops[2] = 7'h67; ops[3] = 7'h03;
    ops[4] = 7'h23; ops[5] = 7'h73; ops[6] = 7'h13;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    model_step(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 500; c++) begin
      rr  = ($urandom_range(0, 59) != 0);
      rfl = ($urandom_range(0, 24) == 0);
      rpv = ($urandom_range(0, 3) != 0);
      rnr = ($urandom_range(0, 2) != 0);
      rpc = $urandom;
      rnd = $urandom;
      rinst = rnd;
      if ($urandom_range(0, 4) != 0) rinst[6:0] = ops[$urandom_range(0, 6)];
      apply_stimulus(rr, rpv, rfl, rnr, rpc, rinst);
      model_step(rr, rpv, rfl, rnr, rpc, rinst);
      check_model(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_ifq.md
Name: ysyx_ifq

Overview:
Instruction fetch queue sitting directly downstream of the IFU and upstream of the IDU. It buffers fetched (pc, inst) pairs in a small circular FIFO so IFU stalls and IDU stalls are decoupled. At enqueue it pre-decodes each RV32 instruction into class flags, which are stored alongside the entry. A flush input discards all entries on redirect.

Parameters:
DATA_W, 32, instruction width
ADDR_W, 32, pc width
DEPTH_LOG2, 2, log2 of queue depth (default depth 4; must be ≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
prev_valid  in  1  IFU output valid (IFU valid_o)
ready_o  out  1  queue can accept an entry
inst_i  in  DATA_W  instruction from IFU
pc_i  in  ADDR_W  pc of inst_i
flush_i  in  1  redirect: discard all entries
valid_o  out  1  head entry valid toward IDU
next_ready  in  1  IDU accepts head
inst_o  out  DATA_W  head instruction
pc_o  out  ADDR_W  head pc
pd_o  out  7  pre-decode flags of head {ill, sys, store, load, jalr, jal, branch}, bit 0 = branch
count_o  out  DEPTH_LOG2+1  current occupancy

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- While rst=0 at a clock edge: head ptr, tail ptr and count clear to 0. Storage is not cleared.
- Outputs after reset: valid_o=0, ready_o=1, count_o=0, inst_o=0, pc_o=0, pd_o=0.
- ready_o = (count != depth). Combinational from registered count; no dependency on next_ready.
- valid_o = (count != 0).
- inst_o, pc_o and pd_o read the head entry. They are forced to 0 when count==0.
- Enqueue: prev_valid & ready_o & !flush_i. Writes {pc_i, inst_i, pd} at tail; tail advances by 1.
- Dequeue: valid_o & next_ready & !flush_i. Head advances by 1.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth naturally.
- Count update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Latency: an entry enqueued at edge N is visible on valid_o after edge N. There is no combinational bypass from inst_i to inst_o.
- Full with simultaneous dequeue: ready_o stays 0 that cycle, so no enqueue occurs. Next cycle count=depth-1 and ready_o=1.
- Empty: valid_o=0 and next_ready is ignored. An enqueue into an empty queue yields count=1 next cycle.
- Flush has priority over both enqueue and dequeue. At the edge where flush_i=1: head=tail=0, count=0, and any handshake in that cycle is discarded. Next cycle valid_o=0 and ready_o=1.
- Reset has priority over flush.
- Reset asserted mid-operation behaves identically to power-up reset on the next edge.
- Pre-decode uses opcode = inst[6:0]:
  - branch: 1100011
  - jal: 1101111
  - jalr: 1100111
  - load: 0000011
  - store: 0100011
  - sys: 1110011
  - ill: inst[1:0] != 2'b11
  - At most one class flag is set; all flags are 0 for ALU/LUI/AUIPC/FENCE.
- Storage is a register array of depth entries, each ADDR_W+DATA_W+7 bits.

Decomposition:
- Shared package (ysyx_macro): RV32 opcode constants (OP_BRANCH, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, OP_SYSTEM) and pre-decode bit indices (PD_BRANCH..PD_ILL, PD_W=7).
- One natural sub-module: ysyx_ifq_predecode, purely combinational, inst -> 7-bit flags. It is reusable by the IDU for consistency checks.
- FIFO control and storage stay in ysyx_ifq.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> valid_o=0, ready_o=1, count_o=0, inst_o=0, pc_o=0.
- Fill and drain: next_ready=0; enqueue pc 0x80000000/0x80000004/0x80000008/0x8000000C with inst 0x00000013, 0x0000006F, 0x00008067, 0x00002003. Expected: ready_o=0 after 4th edge, count_o=4. Then next_ready=1 -> outputs appear in order with pd_o=0x00, 0x02, 0x04, 0x08, and valid_o=0 after 4 dequeues.
- Simultaneous enq/deq at count=2 with next_ready=1 and prev_valid=1 for 6 cycles -> count_o stays 2, and pointers wrap past entry 3 with order preserved.
- Full plus dequeue: count=4, prev_valid=1, next_ready=1 -> no enqueue that cycle, count_o=3 next cycle, ready_o=1.
- Flush: count=3, flush_i=1 with prev_valid=1 and next_ready=1 in the same cycle -> next cycle count_o=0, valid_o=0, and the flushed-cycle inst never appears at the output.
- Pre-decode sweep: enqueue 0x00000063, 0x00002023, 0x00000073, 0x00000000 -> pd_o=0x01, 0x10, 0x20, 0x40.
